muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle RV32M multiply/divide unit, parametrised in operand width. Replaces single-cycle combinational `*`, `/` and `%` in the execute stage with a start/done handshake so those operations leave the critical path. Sits beside the ALU: the decoder raises `start` for an M-extension instruction, and the pipeline stalls on `busy` until `done`.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; legal values are even and ≥ 8.
- `CNT_W`, default `$clog2(XLEN)+1`: iteration counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: launch request, sampled only while `busy`=0.
- `op` in 3: RV32M funct3, sampled with `start`.
  - 000 mul, 001 mulh, 010 mulhsu, 011 mulhu.
  - 100 div, 101 divu, 110 rem, 111 remu.
- `a` in XLEN: rs1 value, sampled with `start`.
- `b` in XLEN: rs2 value, sampled with `start`.
- `flush` in 1: abort the in-flight operation (branch or trap kill).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out XLEN: final value, held until the next accepted `start`.

## Operation
- FSM states:
  - IDLE: accepts `start`.
    - Div-by-zero or signed overflow: go to DONE.
    - Fast multiply: go to DONE.
    - Otherwise: go to CALC.
  - CALC: one radix-2 step per cycle, for exactly XLEN cycles; then go to FIX.
  - FIX: applies sign correction and selects hi/lo half or quotient/remainder; goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Operand preparation at accept:
  - Signed operands (mulh and div/rem signed; `a` only for mulhsu) are converted to magnitude.
  - Negate flags are latched from the operand signs.
  - Unsigned operands pass through unchanged.
- Division uses restoring shift-subtract:
  - 2·XLEN+1-bit remainder/quotient register; the MSB is the subtract borrow.
- Iterative multiplication uses shift-add:
  - 2·XLEN product register.
  - mul returns the low half; mulh, mulhsu and mulhu return the high half.
  - mul uses the same signed path, since the low half is sign-agnostic.
- Sign correction in FIX:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of `a`.
  - Product is negated as a full 2·XLEN two's complement.
- Special cases, resolved in IDLE without entering CALC:
  - `b`=0: div/divu give all-ones; rem/remu give `a`.
  - Signed overflow (`a`=most negative, `b`=−1): div gives `a`; rem gives 0.
- `start` while `busy`=1 is ignored. Operands are registered, so upstream may change `a`, `b` and `op` after accept.
- `flush`:
  - Takes priority over everything.
  - In any non-IDLE state, the next state is IDLE; no `done`; `result` unchanged.
  - `flush` with `start` in the same IDLE cycle: the start is dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously).
- `start` accepted at edge T0 (the first edge with `start`=1 and `busy`=0).
- `busy` behaviour:
  - Goes to 1 after T0.
  - Goes to 0 in the same cycle `done`=1, so back-to-back starts are possible in the cycle after `done`.
- Latency from the accept edge to the `done` cycle:
  - Iterative divide or multiply: XLEN+2 edges (XLEN CALC, 1 FIX, then DONE).
  - Special case or fast multiply: 1 edge.
- `result` updates on the edge entering DONE and is stable from then until the next accept.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - All four multiply ops go IDLE → DONE with a single-cycle registered product, using signed (XLEN+1)-bit operands extended per op.
  - CALC/FIX are used by division only.
- Undefined: multiplies use the iterative shift-add path, with XLEN+2 latency; no hardware multiplier is inferred.
- Results are bit-identical in both builds.

## Test plan
- XLEN=32, iterative build:
  - divu a=100, b=7 → `done` after 34 edges, `result`=14.
  - Then remu with the same operands → 2, with `start` issued the cycle after `done`.
- div a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (−3); rem with the same operands → 0xFFFFFFFF (−1).
- Special cases, each with `done` 1 edge after accept:
  - div a=0x80000000, b=0xFFFFFFFF → 0x80000000.
  - rem with the same operands → 0.
  - divu a=5, b=0 → 0xFFFFFFFF.
- Multiply high halves:
  - mulh a=0x80000000, b=0x80000000 → 0x40000000.
  - mulhsu a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
  - mulhu a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE.
  - Expected latency: 1 edge with `MULDIV_FAST_MUL_EN`, 34 without.
- Abort and ignore:
  - Start divu, assert `flush` at cycle 10 → no `done`, `busy`=0 next cycle, `result` keeps its prior value.
  - `start` pulsed during `busy` → ignored; exactly one `done` observed.
- Reset during CALC: `rst_n`=0 at cycle 5 → `busy`, `done` and `result` are 0 immediately; a new divu after release completes normally.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide with start/done handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle registered multiplies; division stays iterative.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0]   dv_q, dv_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              sa_s, sb_s, sa, sb, neg, div0, ovf;
  logic [XLEN-1:0]   am, bm, spec_res, quo;
  logic [XLEN:0]     diff, sum;
  logic [2*XLEN-1:0] prod;
  assign sa_s     = ~(op[0] & (op[1] | op[2]));
  assign sb_s     = op[2] ? ~op[0] : ~op[1];
  assign sa       = sa_s & a[XLEN-1];
  assign sb       = sb_s & b[XLEN-1];
  assign am       = sa ? -a : a;
  assign bm       = sb ? -b : b;
  // quotient/product sign follows both operands, remainder follows a only
  assign neg      = (op[2] & op[1]) ? sa : sa ^ sb;
  assign div0     = op[2] && b == '0;
  assign ovf      = op[2] && !op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == {XLEN{1'b1}};
  assign spec_res = div0 ? (op[1] ? a : {XLEN{1'b1}}) : (op[1] ? '0 : a);
  assign diff     = acc_q[2*XLEN:XLEN] - {1'b0, dv_q};
  assign sum      = acc_q[2*XLEN:XLEN] + {1'b0, acc_q[0] ? dv_q : '0};
  assign prod     = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
  assign quo      = op_q[1] ? acc_q[2*XLEN:XLEN+1] : acc_q[XLEN-1:0];
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fp;
  logic [XLEN-1:0]   fast_res;
  assign fa       = {{XLEN{sa_s & a[XLEN-1]}}, a};
  assign fb       = {{XLEN{sb_s & b[XLEN-1]}}, b};
  assign fp       = fa * fb;
  assign fast_res = op[1:0] == 2'b00 ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dv_d     = dv_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        op_d  = op;
        neg_d = neg;
        dv_d  = bm;
        // divide keeps the dividend pre-shifted by one so the partial remainder sits in the top XLEN+1 bits
        acc_d = op[2] ? {{XLEN{1'b0}}, am, 1'b0} : {1'b0, {XLEN{1'b0}}, am};
        if (div0 || ovf) begin
          state_d  = DONE;
          result_d = spec_res;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!op[2]) begin
          state_d  = DONE;
          result_d = fast_res;
        end
`endif
        else state_d = CALC;
      end
      CALC: begin
        acc_d = op_q[2] ? {diff[XLEN] ? acc_q[2*XLEN-1:XLEN] : diff[XLEN-1:0], acc_q[XLEN-1:0], ~diff[XLEN]}
                        : {1'b0, sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        state_d  = DONE;
        result_d = op_q[2] ? (neg_q ? -quo : quo) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
      end
      DONE: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dv_q     <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dv_q     <= dv_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end
  assign busy   = state_q == CALC || state_q == FIX;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table, randomized ops against an arithmetic model, and flush/reset/ignore sequences.
module tb_muldiv_seq;
  localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;
  int total = 0, bad = 0;

  typedef struct {logic [2:0] o; logic [31:0] x; logic [31:0] y; logic [31:0] r;} vec_t;
  vec_t vt[14];

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    int ix, iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    ix = int'(x);
    iy = int'(y);
    case (o)
      3'd0: begin p = 64'(ux * uy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: return y == 0 ? 32'hFFFF_FFFF : (x == MIN && y == 32'hFFFF_FFFF) ? x : 32'(ix / iy);
      3'd5: return y == 0 ? 32'hFFFF_FFFF : x / y;
      3'd6: return y == 0 ? x : (x == MIN && y == 32'hFFFF_FFFF) ? 32'h0 : 32'(ix % iy);
      default: return y == 0 ? x : x % y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == MIN && y == 32'hFFFF_FFFF))) return 1;
    if (!o[2] && FAST) return 1;
    return 34;
  endfunction

  // Accept at the first posedge after driving start; lat counts edges from accept to the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output logic bz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    bz  = busy;
    @(posedge clk); #1;
  endtask

  task automatic do_check(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] r);
    logic [31:0] res;
    int lat;
    logic bz;
    run_op(o, x, y, res, lat, bz);
    chk({name, " result"}, res, r);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat(o, x, y)));
    chk({name, " busy_at_done"}, {31'b0, bz}, 32'h0);
    chk({name, " held"}, result, r);
  endtask

  initial begin
    int dcnt;
    logic [31:0] seen, prev;
    vt[0]  = '{3'd5, 32'd100, 32'd7, 32'd14};
    vt[1]  = '{3'd7, 32'd100, 32'd7, 32'd2};
    vt[2]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    vt[3]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    vt[4]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vt[5]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    vt[6]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF};
    vt[7]  = '{3'd7, 32'd5, 32'd0, 32'd5};
    vt[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vt[9]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[10] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[11] = '{3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB};
    vt[12] = '{3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vt[13] = '{3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset result", result, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // vt[0] then vt[1] also exercises a start in the cycle right after done
    for (int i = 0; i < 14; i++) do_check($sformatf("vec%0d", i), vt[i].o, vt[i].x, vt[i].y, vt[i].r);

    for (int i = 0; i < 80; i++) begin
      logic [2:0] o;
      logic [31:0] x, y;
      o = 3'($urandom);
      x = $urandom_range(0, 5) == 0 ? MIN : $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = 32'hFFFF_FFFF;
        2: y = $urandom_range(1, 15);
        default: y = $urandom;
      endcase
      do_check($sformatf("rnd%0d op=%0d a=%h b=%h", i, o, x, y), o, x, y, model(o, x, y));
    end

    // flush mid-divide: no done, busy drops, result keeps prior value
    prev = result;
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'h0);
    chk("flush done", {31'b0, done}, 32'h0);
    chk("flush result", result, prev);
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dcnt++; end
    chk("flush no_done", 32'(dcnt), 32'h0);

    // flush and start together in IDLE: start dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start done", {31'b0, done}, 32'h0);
    chk("flush_start busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    chk("flush_start done2", {31'b0, done}, 32'h0);
    chk("flush_start result", result, prev);

    // start during busy is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd5; b = 32'd0;
    @(negedge clk) start = 1'b0;
    dcnt = 0; seen = '0;
    repeat (60) begin @(posedge clk); #1; if (done) begin dcnt++; seen = result; end end
    chk("ignore done_count", 32'(dcnt), 32'd1);
    chk("ignore result", seen, 32'd333);

    // asynchronous reset during CALC
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'h0);
    chk("midrst done", {31'b0, done}, 32'h0);
    chk("midrst result", result, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    do_check("after_rst divu", 3'd5, 32'd50, 32'd6, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
